// File: rtl/skew_buf_pkg.sv
// Shared types and sizing helpers for the skewed operand tile buffer.
package skew_buf_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  typedef logic bank_idx_t;

  // Valid steps per tile: the last lane finishes ROWS-1 steps after lane 0.
  function automatic int step_count(input int rows, input int k);
    return k + rows - 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skew_bank.sv
// One ROWS x K operand bank: whole-row write port, diagonal read port.
// Lane i shows element t-i of row i inside its window, zero elsewhere.
module skew_bank
  import skew_buf_pkg::*;
#(
  parameter int BITS = 8,
  parameter int ROWS = 8,
  parameter int K    = 8,
  parameter int RW   = 3,
  parameter int TW   = 4
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [RW-1:0]        wr_row_i,
  input  logic [K*BITS-1:0]    wr_data_i,
  input  logic [TW-1:0]        t_i,
  output logic [ROWS*BITS-1:0] lanes_o
);

  logic [K*BITS-1:0] mem_q [ROWS];

  // Storage is deliberately unreset; unwritten rows keep stale contents.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_row_i] <= wr_data_i;
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    logic [BITS-1:0] lane_dat;

    always_comb begin
      lane_dat = '0;
      if (int'(t_i) >= i && int'(t_i) < i + K) begin
        lane_dat = BITS'(mem_q[i] >> ((int'(t_i) - i) * BITS));
      end
    end

    assign lanes_o[i*BITS +: BITS] = lane_dat;
  end

endmodule

// File: rtl/skew_tile_buffer.sv
// Ping-pong operand tile buffer feeding the systolic array with a diagonal skew.
// Host fills the free bank while the committed bank streams K+ROWS-1 steps.
module skew_tile_buffer
  import skew_buf_pkg::*;
#(
  parameter int BITS = 8,
  parameter int ROWS = 8,
  parameter int K    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [cnt_width(ROWS)-1:0] wr_row,
  input  logic [K*BITS-1:0]          wr_data,
  input  logic                       wr_commit,
  output logic                       wr_ready,
  input  logic                       en,
  output logic                       out_valid,
  output logic [ROWS*BITS-1:0]       out_data,
  output logic                       out_first,
  output logic                       out_last,
  output logic                       busy
);

  localparam int STEPS = step_count(ROWS, K);
  localparam int TW    = cnt_width(STEPS);
  localparam int RW    = cnt_width(ROWS);

  state_e          state_q, state_d;
  logic [1:0]      full_q, full_d;
  bank_idx_t       wr_ptr_q, wr_ptr_d;
  bank_idx_t       rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]   t_q, t_d;

  logic            wr_ok;
  logic            wr_acc;
  logic            do_commit;
  logic            last_step;
  logic            stream_rel;
  logic [1:0]      bank_we;
  logic [ROWS*BITS-1:0] lanes0, lanes1;

  assign wr_ok      = !full_q[wr_ptr_q];
  assign wr_acc     = wr_en && wr_ok && (int'(wr_row) < ROWS);
  assign do_commit  = wr_commit && wr_ok;
  assign last_step  = (t_q == TW'(STEPS - 1));
  assign stream_rel = (state_q == ST_STREAM) && en && last_step;
  assign bank_we[0] = wr_acc && !wr_ptr_q;
  assign bank_we[1] = wr_acc && wr_ptr_q;

  skew_bank #(.BITS(BITS), .ROWS(ROWS), .K(K), .RW(RW), .TW(TW)) u_bank0 (
    .clk       (clk),
    .wr_en_i   (bank_we[0]),
    .wr_row_i  (wr_row),
    .wr_data_i (wr_data),
    .t_i       (t_q),
    .lanes_o   (lanes0)
  );

  skew_bank #(.BITS(BITS), .ROWS(ROWS), .K(K), .RW(RW), .TW(TW)) u_bank1 (
    .clk       (clk),
    .wr_en_i   (bank_we[1]),
    .wr_row_i  (wr_row),
    .wr_data_i (wr_data),
    .t_i       (t_q),
    .lanes_o   (lanes1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      full_q   <= 2'b00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      t_q      <= '0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      t_q      <= t_d;
    end
  end

  // On the final step, chain straight into the other bank if it is already full.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_ptr_q]) begin
          state_d = ST_STREAM;
          t_d     = '0;
        end
      end
      ST_STREAM: begin
        if (en) begin
          if (last_step) begin
            rd_ptr_d = ~rd_ptr_q;
            t_d      = '0;
            if (!full_q[~rd_ptr_q]) begin
              state_d = ST_IDLE;
            end
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Release and commit always address different banks, so both may apply.
  always_comb begin
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    if (stream_rel) begin
      full_d[rd_ptr_q] = 1'b0;
    end
    if (do_commit) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end
  end

  always_comb begin
    busy      = (state_q == ST_STREAM);
    out_valid = busy && en;
    out_first = out_valid && (t_q == '0);
    out_last  = out_valid && last_step;
    wr_ready  = wr_ok;
    out_data  = '0;
    if (busy) begin
      out_data = rd_ptr_q ? lanes1 : lanes0;
    end
  end

endmodule

// File: tb/tb_skew_tile_buffer.sv
// Directed table-driven bench: 4x4 instance for banking/stall/reset, 8x3 for non-square skew.
module tb_skew_tile_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_wr_en, a_wr_commit, a_en;
  logic [1:0]  a_wr_row;
  logic [31:0] a_wr_data;
  logic        a_wr_ready, a_out_valid, a_out_first, a_out_last, a_busy;
  logic [31:0] a_out_data;

  logic        b_wr_en, b_wr_commit, b_en;
  logic [2:0]  b_wr_row;
  logic [23:0] b_wr_data;
  logic        b_wr_ready, b_out_valid, b_out_first, b_out_last, b_busy;
  logic [63:0] b_out_data;

  skew_tile_buffer #(.BITS(8), .ROWS(4), .K(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_row(a_wr_row), .wr_data(a_wr_data),
    .wr_commit(a_wr_commit), .wr_ready(a_wr_ready), .en(a_en), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_first(a_out_first), .out_last(a_out_last), .busy(a_busy)
  );

  skew_tile_buffer #(.BITS(8), .ROWS(8), .K(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_data(b_wr_data),
    .wr_commit(b_wr_commit), .wr_ready(b_wr_ready), .en(b_en), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_first(b_out_first), .out_last(b_out_last), .busy(b_busy)
  );

  // exp = {valid, first, last, wr_ready, busy, data[31:0]}
  typedef struct {
    logic        en;
    logic        we;
    logic [1:0]  row;
    logic [31:0] wd;
    logic        cm;
    logic [36:0] exp;
  } vec_t;

  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] sa[7];
  logic [31:0] wa[4];
  logic [31:0] wb[4];

  function automatic logic [31:0] pk4(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic vec_t mk(input bit en, input bit we, input int row, input logic [31:0] wd,
                              input bit cm, input bit ev, input bit ef, input bit el,
                              input bit er, input bit eb, input logic [31:0] ed);
    vec_t r;
    r.en  = en;
    r.we  = we;
    r.row = 2'(row);
    r.wd  = wd;
    r.cm  = cm;
    r.exp = {ev, ef, el, er, eb, ed};
    return r;
  endfunction

  // Tile B (4x4): element c of row r is -1-10r-c.
  function automatic logic [31:0] sb4(input int t);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (t >= i && t < i + 4) r[i*8 +: 8] = 8'(-1 - 10*i - (t - i));
    return r;
  endfunction

  // 8x3 tile: element c of row r is 10r+c.
  function automatic logic [63:0] sb8(input int t);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++)
      if (t >= i && t < i + 3) r[i*8 +: 8] = 8'(10*i + (t - i));
    return r;
  endfunction

  task automatic cmp(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v);
    a_en = v.en; a_wr_en = v.we; a_wr_row = v.row; a_wr_data = v.wd; a_wr_commit = v.cm;
  endtask

  task automatic check_a(input string tag, input logic [36:0] exp);
    cmp(tag, {a_out_valid, a_out_first, a_out_last, a_wr_ready, a_busy, a_out_data}, exp);
  endtask

  task automatic apply_a(input vec_t v, input string tag);
    drive_a(v);
    #1;
    check_a(tag, v.exp);
    @(posedge clk); #1;
  endtask

  initial begin
    bit stall_pat[13] = '{0,1,0,1,1,0,0,1,0,1,1,0,1};
    int s;
    vec_t v;

    sa[0] = pk4(0, 0, 0, 0);   sa[1] = pk4(1, 10, 0, 0);  sa[2] = pk4(2, 11, 20, 0);
    sa[3] = pk4(3, 12, 21, 30); sa[4] = pk4(0, 13, 22, 31); sa[5] = pk4(0, 0, 23, 32);
    sa[6] = pk4(0, 0, 0, 33);
    for (int r = 0; r < 4; r++) begin
      wa[r] = pk4(10*r, 10*r + 1, 10*r + 2, 10*r + 3);
      wb[r] = pk4(-1 - 10*r, -2 - 10*r, -3 - 10*r, -4 - 10*r);
    end

    // Single tile into bank 0; last row written in the commit cycle.
    for (int r = 0; r < 4; r++) tbl.push_back(mk(1, 1, r, wa[r], r == 3, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int t = 0; t < 7; t++) tbl.push_back(mk(1, 0, 0, 0, 0, 1, t == 0, t == 6, 1, 1, sa[t]));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    // Same tile into bank 1, streamed with en stalls.
    for (int r = 0; r < 4; r++) tbl.push_back(mk(1, 1, r, wa[r], r == 3, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    s = 0;
    foreach (stall_pat[i]) begin
      if (stall_pat[i]) begin
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, s == 0, s == 6, 1, 1, sa[s]));
        s++;
      end else begin
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, sa[s]));
      end
    end
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    // Back-to-back: B loaded during A, overrun attempted while both banks full.
    for (int r = 0; r < 4; r++) tbl.push_back(mk(1, 1, r, wa[r], r == 3, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int t = 0; t < 4; t++) tbl.push_back(mk(1, 1, t, wb[t], t == 3, 1, t == 0, 0, 1, 1, sa[t]));
    tbl.push_back(mk(1, 1, 0, 32'h7F7F_7F7F, 1, 1, 0, 0, 0, 1, sa[4]));
    tbl.push_back(mk(1, 1, 1, 32'h7F7F_7F7F, 0, 1, 0, 0, 0, 1, sa[5]));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 1, sa[6]));
    for (int t = 0; t < 7; t++) tbl.push_back(mk(1, 0, 0, 0, 0, 1, t == 0, t == 6, 1, 1, sb4(t)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    rst_n = 1'b0;
    drive_a(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    b_en = 1'b0; b_wr_en = 1'b0; b_wr_row = '0; b_wr_data = '0; b_wr_commit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_a("reset_a", {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
    cmp("reset_b", {b_out_valid, b_out_first, b_out_last, b_wr_ready, b_busy, b_out_data},
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) apply_a(tbl[i], $sformatf("vec%0d", i));

    // Reset mid-stream at step 2 of a fresh tile in bank 0.
    for (int r = 0; r < 4; r++) apply_a(mk(1, 1, r, wa[r], r == 3, 0, 0, 0, 1, 0, 0), "rst_load");
    apply_a(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rst_idle");
    apply_a(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 1, sa[0]), "rst_s0");
    apply_a(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 1, sa[1]), "rst_s1");
    v = mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 1, sa[2]);
    drive_a(v);
    #1;
    check_a("rst_s2", v.exp);
    rst_n = 1'b0;
    #1;
    check_a("rst_async", {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    check_a("rst_held", {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
    rst_n = 1'b1;
    // Commit without rewriting: bank 0 still holds the tile from before reset.
    apply_a(mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), "post_commit");
    apply_a(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "post_idle");
    apply_a(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 1, sa[0]), "post_s0");
    apply_a(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 1, sa[1]), "post_s1");
    drive_a(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Non-square 8x3 instance.
    for (int r = 0; r < 8; r++) begin
      b_en = 1'b1; b_wr_en = 1'b1; b_wr_row = 3'(r);
      b_wr_data = {8'(10*r + 2), 8'(10*r + 1), 8'(10*r)};
      b_wr_commit = (r == 7);
      @(posedge clk); #1;
    end
    b_wr_en = 1'b0; b_wr_commit = 1'b0;
    #1;
    cmp("b_idle", {b_out_valid, b_busy, b_wr_ready}, {1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;
    for (int t = 0; t < 10; t++) begin
      #1;
      cmp($sformatf("b_step%0d", t), {b_out_valid, b_out_first, b_out_last, b_out_data},
          {1'b1, t == 0, t == 9, sb8(t)});
      cmp($sformatf("b_lane7_%0d", t), {127'h0, b_out_data[63:56] != 8'h0}, {127'h0, t >= 7});
      @(posedge clk); #1;
    end
    #1;
    cmp("b_done", {b_out_valid, b_busy, b_out_data}, {1'b0, 1'b0, 64'h0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/skew_tile_buffer.md
# skew_tile_buffer

Double-buffered operand skew buffer for the systolic matrix-multiply array. It accepts an operand tile one row per cycle into the free bank. It then streams the previously committed tile into the array's lane inputs with a diagonal skew: lane i is delayed i cycles and zero-padded outside its window. Ping-pong banking lets the host load tile N+1 while tile N streams, with no bubble between back-to-back tiles.

## Interface
- BITS, 8, signed element width
- ROWS, 8, number of array lanes (tile rows)
- K, 8, elements per lane per tile (tile columns); ROWS and K independent
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write wr_data into row wr_row of write bank
- wr_row  in  $clog2(ROWS)  target row; values >= ROWS ignored
- wr_data  in  signed [BITS-1:0] x K  one tile row, element 0 streams first
- wr_commit  in  1  mark write bank complete, hand it to stream side
- wr_ready  out  1  write bank is free (not committed)
- en  in  1  advance stream by one step (array enable)
- out_valid  out  1  out_data is a live skewed step this cycle
- out_data  out  signed [BITS-1:0] x ROWS  lane outputs
- out_first  out  1  first step of a tile
- out_last  out  1  final step of a tile
- busy  out  1  stream FSM in STREAM

## Operation
- State: bank storage [2][ROWS][K], full[1:0], wr_ptr, rd_ptr, FSM {IDLE, STREAM}, step counter t of width $clog2(K+ROWS-1).
- Write side: wr_en with full[wr_ptr]==0 writes row wr_row of bank wr_ptr. Writes while full are dropped. Rows never written keep stale contents.
- Commit: wr_commit with full[wr_ptr]==0 sets full[wr_ptr] and toggles wr_ptr. Commit while full is ignored. wr_ready = !full[wr_ptr].
- IDLE: if full[rd_ptr], go to STREAM with t=0.
- STREAM: when en is high, t increments. At t == K+ROWS-2 with en high, clear full[rd_ptr] and toggle rd_ptr. Then:
  - if the other bank is already full, stay in STREAM with t=0 (no bubble);
  - otherwise go to IDLE.
- en low in STREAM: t and all outputs hold; out_valid=0.
- Lane data: out_data[i] = bank[rd_ptr][i][t-i] when i <= t < i+K, else 0. Lane 0 is never delayed.
- out_valid = STREAM && en.
- out_first = out_valid && t==0.
- out_last = out_valid && t==K+ROWS-2.
- Tile length: exactly K+ROWS-1 valid steps.

## Timing
- Reset: full=0, wr_ptr=rd_ptr=0, t=0, FSM=IDLE. Outputs reset to: wr_ready=1, out_valid=0, out_first=0, out_last=0, busy=0, out_data all 0.
- Write: data is visible to a stream that starts one cycle or more later.
- Commit to first valid step:
  - commit at edge n sets full;
  - FSM enters STREAM at edge n+1;
  - out_valid (with en=1) is high in the cycle after edge n+1.
- wr_en and wr_commit in the same cycle: the row is written, then the bank is committed; the row is included in the tile.
- Release and commit in the same cycle on opposite banks: both take effect. wr_ready returns 1 the cycle after release.
- Release of bank b and commit into bank b cannot coincide: the write side only targets the bank that is not full.
- Reset mid-stream: immediate abort. Both banks become empty, outputs drop to their reset values asynchronously.
- out_data is combinational from registered state (bank, rd_ptr, t). No output register stage.

## Structure
- Package skew_buf_pkg: localparam function for step count (K+ROWS-1), FSM state enum, bank-index typedef.
- Sub-module skew_bank: one bank's ROWS x K storage, with a row-write port and a diagonal read port (t in, ROWS lanes out, zero padding). Instantiate it twice; the top holds the FSM, pointers and full flags, and muxes between banks on rd_ptr.

## Test plan
- Single tile, ROWS=K=4, row r = {10r+0..10r+3}, commit, en=1 → 7 valid steps. Step 0 = {0,0,0,0}... (lane0=0, others 0). Step 3 = {3,12,21,30}. Step 6 = {0,0,0,33}. out_first at step 0, out_last at step 6.
- Back-to-back: commit tile A, load and commit tile B during A's stream → B's step 0 follows A's out_last on the next en cycle. wr_ready is 0 while both banks are full.
- Stall: toggle en 0/1 randomly during a stream → the sequence of valid steps is identical to the en=1 run. out_valid is 0 on every en=0 cycle.
- Overrun: commit both banks, then issue wr_en and wr_commit → ignored. Streamed data is unchanged; wr_ready stays 0 until the first release.
- Non-square ROWS=8, K=3 → 10 valid steps. Lane 7 is nonzero only at steps 7..9.
- Reset asserted at step 2 of a stream → busy=0, out_valid=0, wr_ready=1 immediately. A new commit after release of reset streams from t=0.
